tcb_cmn_gpio: RTL and testbench
===============================

TCB_CMN_GPIO -- requirements
Module: tcb_cmn_gpio

Interface
REQ-001 SHALL have parameter GW, default 32: GPIO width in bits, 1..DBW.
REQ-002 SHALL have parameter CFG_CDC, default 2: number of input synchronizer stages; 0 means no synchronizer.
REQ-003 SHALL have parameter CFG_MIN, default 0: 1 selects the minimal implementation (REQ-020).
REQ-004 SHALL have parameter CHIP, default "": target device string; the generic flop implementation is used for every value.
REQ-005 SHALL have one clock; reset is asynchronous and active-high; both are taken as clk and rst from the tcb_if instance.
REQ-006 SHALL have port tcb, modport subordinate of tcb_if, with ABW=32, DBW=32, byte enables, read delay DLY=1.
REQ-007 SHALL have port gpio_o, output, GW bits: pin output values.
REQ-008 SHALL have port gpio_e, output, GW bits: pin output enables, 1 = drive.
REQ-009 SHALL have port gpio_i, input, GW bits: asynchronous pin inputs.

Function
REQ-010 SHALL always assert tcb.rdy, so a transfer completes in the cycle tcb.vld=1.
REQ-011 SHALL decode tcb.adr[3:2] only: 0 = OUT (rw), 1 = ENA (rw), 2 = INP (ro), 3 = unmapped; higher address bits alias.
REQ-012 SHALL update OUT or ENA on the rising clk edge of a write handshake, per byte lane where tcb.byt[i]=1; lanes above GW are ignored.
REQ-013 SHALL ignore writes to INP and to the unmapped address.
REQ-014 SHALL drive gpio_o from OUT and gpio_e from ENA with no extra delay, so a new value is visible one cycle after the write handshake.
REQ-015 SHALL pass gpio_i through CFG_CDC flops; INP is the last stage, or gpio_i when CFG_CDC=0.
REQ-016 SHALL present read data on tcb.rdt exactly one cycle after the read handshake, zero-extended from GW to DBW.
REQ-017 SHALL return 0 on reads of the unmapped address.
REQ-018 SHALL return tcb.sts error = 0 for every access, including unmapped ones.
REQ-019 SHALL let back-to-back transfers, one per cycle, each produce their own response; a read of a register in the cycle after a write to it returns the new value.
REQ-020 When CFG_MIN=1, SHALL return 0 on reads of OUT and ENA, leaving INP the only readable register, and SHALL ignore byte enables, writing full words.

Reset
REQ-021 While rst=1, SHALL force OUT=0, ENA=0, all synchronizer stages to 0 and the rdt register to 0, asynchronously.
REQ-022 SHALL hold gpio_o=0 and gpio_e=0 from reset assertion until the first write.
REQ-023 SHALL give a transfer completed in the same cycle as reset assertion no effect and no valid response.

Structure
REQ-024 SHALL take TCB parameter/status types (tcb_par_phy_t, tcb_rsp_sts_def_t) from the shared tcb_pkg.
REQ-025 SHALL place register offsets (0x00, 0x04, 0x08) as localparams in the module.
REQ-026 SHALL implement the input synchronizer as sub-module tcb_gpio_cdc, with parameters CFG_CDC, GW and CHIP.
REQ-027 SHALL have a sibling tcb_ind_gpio (separate write and read channels tcb_wrc and tcb_rdc) with an identical register map, sharing tcb_gpio_cdc.

Verification
REQ-028 Reset, then write 0x00 = 0x01234567 and 0x04 = 0x76543210 -> next cycle gpio_o=0x01234567 and gpio_e=0x76543210; sts=0.
REQ-029 Read 0x00 and 0x04 -> rdt=0x01234567 and 0x76543210 one cycle after each handshake.
REQ-030 Drive gpio_i=0x89abcdef, wait 2 cycles, read 0x08 -> 0x89abcdef; then drive 0xfedcba98, wait 2 cycles, read 0x08 -> 0xfedcba98.
REQ-031 Change gpio_i and read 0x08 one cycle later with CFG_CDC=2 -> the old value is returned.
REQ-032 Write 0x00 = 0xffffffff with byt=0b0010 over OUT=0x01234567 -> OUT=0x0123ff67; a write to 0x08 leaves INP unchanged.
REQ-033 Read 0x0C -> rdt=0 and sts=0; assert rst during activity -> gpio_o=0 and gpio_e=0 immediately.

Source files
------------

// File: rtl/tcb_cmn_gpio_pkg.sv
// GPIO register map selector and byte-lane helper shared by the GPIO peripherals.
package tcb_cmn_gpio_pkg;

  typedef enum logic [1:0] {
    REG_OUT = 2'd0,
    REG_ENA = 2'd1,
    REG_INP = 2'd2,
    REG_NON = 2'd3
  } gpio_reg_e;

  // Expands a 4-bit byte-enable vector into a 32-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] byt);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{byt[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tcb_pkg.sv
// Shared TCB bus types: physical bus parameters and the default response status.
package tcb_pkg;

  typedef struct packed {
    int unsigned ABW;
    int unsigned DBW;
    int unsigned DLY;
  } tcb_par_phy_t;

  typedef struct packed {
    logic err;
  } tcb_rsp_sts_def_t;

  localparam tcb_par_phy_t TCB_PAR_PHY_DEF = '{ABW: 32, DBW: 32, DLY: 1};

endpackage

// File: rtl/tcb_if.sv
// TCB bus interface: one request/response channel with byte enables and status.
interface tcb_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned DLY = 1
)(
  input logic clk,
  input logic rst
);
  logic                        vld;
  logic                        wen;
  logic [ABW-1:0]              adr;
  logic [DBW/8-1:0]            byt;
  logic [DBW-1:0]              wdt;
  logic                        rdy;
  logic [DBW-1:0]              rdt;
  tcb_pkg::tcb_rsp_sts_def_t   sts;

  modport manager (
    input  clk, rst,
    output vld, wen, adr, byt, wdt,
    input  rdy, rdt, sts
  );

  modport subordinate (
    input  clk, rst,
    input  vld, wen, adr, byt, wdt,
    output rdy, rdt, sts
  );
endinterface

// File: rtl/tcb_gpio_cdc.sv
// Input synchronizer for GPIO pins: CFG_CDC flop stages, or a plain wire when zero.
module tcb_gpio_cdc #(
  parameter int unsigned CFG_CDC = 2,
  parameter int unsigned GW      = 32,
  parameter string       CHIP    = ""
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] gpio_i,
  output logic [GW-1:0] gpio_s
);
  // Every target uses the generic flop chain.
  localparam bit unused_chip = (CHIP != "");

  if (CFG_CDC == 0) begin : gen_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign gpio_s = gpio_i;
  end else begin : gen_sync
    logic [GW-1:0] sync_q [CFG_CDC];
    logic [GW-1:0] sync_d [CFG_CDC];

    always_comb begin
      sync_d[0] = gpio_i;
      for (int unsigned i = 1; i < CFG_CDC; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < CFG_CDC; i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q <= sync_d;
      end
    end

    assign gpio_s = sync_q[CFG_CDC-1];
  end
endmodule

// File: rtl/tcb_cmn_gpio.sv
// GPIO peripheral on a TCB subordinate port: OUT/ENA registers, synchronized INP, 1-cycle read data.
module tcb_cmn_gpio
  import tcb_pkg::*;
  import tcb_cmn_gpio_pkg::*;
#(
  parameter int unsigned GW      = 32,
  parameter int unsigned CFG_CDC = 2,
  parameter bit          CFG_MIN = 1'b0,
  parameter string       CHIP    = ""
)(
  tcb_if.subordinate    tcb,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_e,
  input  logic [GW-1:0] gpio_i
);
  localparam tcb_par_phy_t PHY = TCB_PAR_PHY_DEF;
  localparam int unsigned  DBW = PHY.DBW;

  localparam logic [3:0] OFS_OUT = 4'h0;
  localparam logic [3:0] OFS_ENA = 4'h4;
  localparam logic [3:0] OFS_INP = 4'h8;

  logic [GW-1:0]  out_q, out_d;
  logic [GW-1:0]  ena_q, ena_d;
  logic [DBW-1:0] rdt_q, rdt_d;
  logic [GW-1:0]  inp;
  logic [DBW-1:0] wmask;
  logic [3:0]     adr_ofs;
  gpio_reg_e      sel;
  logic           trn;
  logic           unused_adr;

  tcb_gpio_cdc #(
    .CFG_CDC (CFG_CDC),
    .GW      (GW),
    .CHIP    (CHIP)
  ) u_cdc (
    .clk    (tcb.clk),
    .rst    (tcb.rst),
    .gpio_i (gpio_i),
    .gpio_s (inp)
  );

  // Only adr[3:2] is decoded; every other address bit aliases.
  assign unused_adr = ^{tcb.adr[PHY.ABW-1:4], tcb.adr[1:0]};
  assign adr_ofs    = {tcb.adr[3:2], 2'b00};
  assign trn        = tcb.vld & tcb.rdy;

  always_comb begin
    if (adr_ofs == OFS_OUT)      sel = REG_OUT;
    else if (adr_ofs == OFS_ENA) sel = REG_ENA;
    else if (adr_ofs == OFS_INP) sel = REG_INP;
    else                         sel = REG_NON;
  end

  always_comb begin
    out_d = out_q;
    ena_d = ena_q;
    rdt_d = rdt_q;
    wmask = CFG_MIN ? '1 : byte_mask(tcb.byt);
    if (trn) begin
      if (tcb.wen) begin
        case (sel)
          REG_OUT: out_d = (out_q & ~wmask[GW-1:0]) | (tcb.wdt[GW-1:0] & wmask[GW-1:0]);
          REG_ENA: ena_d = (ena_q & ~wmask[GW-1:0]) | (tcb.wdt[GW-1:0] & wmask[GW-1:0]);
          default: ;
        endcase
      end else begin
        rdt_d = '0;
        case (sel)
          REG_OUT: if (!CFG_MIN) rdt_d[GW-1:0] = out_q;
          REG_ENA: if (!CFG_MIN) rdt_d[GW-1:0] = ena_q;
          REG_INP: rdt_d[GW-1:0] = inp;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge tcb.clk or posedge tcb.rst) begin
    if (tcb.rst) begin
      out_q <= '0;
      ena_q <= '0;
      rdt_q <= '0;
    end else begin
      out_q <= out_d;
      ena_q <= ena_d;
      rdt_q <= rdt_d;
    end
  end

  assign tcb.rdy = 1'b1;
  assign tcb.rdt = rdt_q;
  assign tcb.sts = '0;
  assign gpio_o  = out_q;
  assign gpio_e  = ena_q;
endmodule

// File: tb/tb_tcb_cmn_gpio.sv
// Self-checking bench for tcb_cmn_gpio: directed register-map steps plus randomized traffic vs. a reference model.
module tb_tcb_cmn_gpio;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] gpio_o, gpio_e, gpio_i;

  tcb_if #(.ABW(32), .DBW(32), .DLY(1)) bus (.clk(clk), .rst(rst));

  tcb_cmn_gpio #(
    .GW      (32),
    .CFG_CDC (2),
    .CFG_MIN (1'b0),
    .CHIP    ("")
  ) dut (
    .tcb    (bus),
    .gpio_o (gpio_o),
    .gpio_e (gpio_e),
    .gpio_i (gpio_i)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: register contents and the per-cycle history of pin values.
  logic [31:0] m_out, m_ena;
  logic [31:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    m_ena = '0;
    hist.delete();
    hist.push_back(32'h0);
    hist.push_back(32'h0);
  endtask

  // One bus cycle: drive, predict, clock, then compare away from the edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] gi, input string tag);
    logic [31:0] exp_rd, mask;
    logic [1:0]  reg_sel;
    bus.vld = v; bus.wen = w; bus.adr = a; bus.byt = b; bus.wdt = d;
    gpio_i  = gi;
    hist.push_back(gi);
    reg_sel = a[3:2];
    case (reg_sel)
      2'd0:    exp_rd = m_out;
      2'd1:    exp_rd = m_ena;
      2'd2:    exp_rd = hist[hist.size()-3];
      default: exp_rd = 32'h0;
    endcase
    if (v && w) begin
      mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      if (reg_sel == 2'd0) m_out = (m_out & ~mask) | (d & mask);
      if (reg_sel == 2'd1) m_ena = (m_ena & ~mask) | (d & mask);
    end
    @(posedge clk);
    #1;
    bus.vld = 1'b0;
    if (v) begin
      check({tag, " sts"}, {31'b0, bus.sts.err}, 32'h0);
      if (!w) check({tag, " rdt"}, bus.rdt, exp_rd);
    end
    check({tag, " gpio_o"}, gpio_o, m_out);
    check({tag, " gpio_e"}, gpio_e, m_ena);
  endtask

  initial begin
    logic [31:0] gi, ra;
    bus.vld = 1'b0; bus.wen = 1'b0; bus.adr = '0; bus.byt = '0; bus.wdt = '0;
    gpio_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset gpio_o", gpio_o, 32'h0);
    check("reset gpio_e", gpio_e, 32'h0);
    check("reset rdt", bus.rdt, 32'h0);
    rst = 1'b0;
    model_reset();

    step(1, 1, 32'h00, 4'hf, 32'h01234567, 32'h0, "wr OUT");
    step(1, 1, 32'h04, 4'hf, 32'h76543210, 32'h0, "wr ENA");
    check("OUT value", gpio_o, 32'h01234567);
    check("ENA value", gpio_e, 32'h76543210);
    step(1, 0, 32'h00, 4'hf, 32'h0, 32'h0, "rd OUT");
    step(1, 0, 32'h04, 4'hf, 32'h0, 32'h0, "rd ENA");

    step(0, 0, 32'h0, 4'h0, 32'h0, 32'h89abcdef, "pin a0");
    step(0, 0, 32'h0, 4'h0, 32'h0, 32'h89abcdef, "pin a1");
    step(1, 0, 32'h08, 4'hf, 32'h0, 32'h89abcdef, "rd INP a");
    check("INP a", bus.rdt, 32'h89abcdef);
    step(0, 0, 32'h0, 4'h0, 32'h0, 32'hfedcba98, "pin b0");
    step(0, 0, 32'h0, 4'h0, 32'h0, 32'hfedcba98, "pin b1");
    step(1, 0, 32'h08, 4'hf, 32'h0, 32'hfedcba98, "rd INP b");
    check("INP b", bus.rdt, 32'hfedcba98);
    step(0, 0, 32'h0, 4'h0, 32'h0, 32'h13579bdf, "pin c0");
    step(1, 0, 32'h08, 4'hf, 32'h0, 32'h13579bdf, "rd INP stale");
    check("INP stale", bus.rdt, 32'hfedcba98);

    step(1, 1, 32'h00, 4'b0010, 32'hffffffff, 32'h13579bdf, "wr OUT lane1");
    check("OUT lane1", gpio_o, 32'h0123ff67);
    step(1, 1, 32'h08, 4'hf, 32'h00000000, 32'h13579bdf, "wr INP");
    step(1, 0, 32'h08, 4'hf, 32'h0, 32'h13579bdf, "rd INP after wr");
    step(1, 0, 32'h0c, 4'hf, 32'h0, 32'h13579bdf, "rd unmapped");
    check("unmapped rdt", bus.rdt, 32'h0);
    step(1, 0, 32'hfff0, 4'hf, 32'h0, 32'h13579bdf, "rd OUT alias");
    step(1, 1, 32'h04, 4'hf, 32'h5a5a0f0f, 32'h13579bdf, "wr ENA b2b");
    step(1, 0, 32'h04, 4'hf, 32'h0, 32'h13579bdf, "rd ENA b2b");

    gi = 32'h13579bdf;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) gi = $urandom;
      ra = {$urandom_range(0, 255), 2'b00, 2'b00} | ({30'h0, 2'($urandom_range(0, 3))} << 2);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, 4'($urandom_range(0, 15)),
           $urandom, gi, "rand");
    end

    step(1, 1, 32'h00, 4'hf, 32'hcafef00d, gi, "pre-rst OUT");
    step(1, 1, 32'h04, 4'hf, 32'hffffffff, gi, "pre-rst ENA");
    bus.vld = 1'b1; bus.wen = 1'b1; bus.adr = 32'h0; bus.byt = 4'hf; bus.wdt = 32'hdeadbeef;
    #4;
    rst = 1'b1;
    #1;
    check("async rst gpio_o", gpio_o, 32'h0);
    check("async rst gpio_e", gpio_e, 32'h0);
    @(posedge clk);
    #1;
    bus.vld = 1'b0;
    check("rst xfer gpio_o", gpio_o, 32'h0);
    check("rst xfer rdt", bus.rdt, 32'h0);
    rst = 1'b0;
    model_reset();
    step(0, 0, 32'h0, 4'h0, 32'h0, gi, "post-rst idle");
    step(1, 0, 32'h00, 4'hf, 32'h0, gi, "post-rst rd OUT");
    step(1, 0, 32'h08, 4'hf, 32'h0, gi, "post-rst rd INP");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
